snes_joy_responder: RTL and testbench

Controller-side responder for the SNES serial joypad port. It answers the console's `JOY_STRB`/`JOY_CLK` protocol on `JOY_DI`, the other end of the `JOY1_*`/`JOY2_*` pins the SNES core drives. It can act as a standard 12-button pad or as an SNES mouse, and sits in the top level between the host input layer and one console port. It latches button/motion state on strobe and shifts one bit per clock pulse, with the same polarity as the real pad line.

---
 rtl/snes_joy_responder.sv | 173 +++++++++++++++++
 tb/tb_snes_joy_responder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/snes_joy_responder.sv
// Controller-side responder for the SNES serial joypad port.
// Emulates a 12-button pad or, when MOUSE_EN=1, an SNES mouse.
module snes_joy_responder #(
  parameter bit MOUSE_EN = 1'b1,
  localparam int unsigned BTN_W   = 12,
  localparam int unsigned DELTA_W = 9
) (
  input  logic               MCLK,
  input  logic               RESET,
  input  logic               JOY_STRB,
  input  logic               JOY_CLK,
  output logic [1:0]         JOY_DI,
  input  logic               MOUSE_MODE,
  input  logic [BTN_W-1:0]   BUTTONS,
  input  logic [DELTA_W-1:0] MOUSE_DX,
  input  logic [DELTA_W-1:0] MOUSE_DY,
  input  logic [1:0]         MOUSE_BTN,
  input  logic               MOUSE_STB
);

  localparam int unsigned SR_W    = 32;
  localparam int unsigned ACC_W   = 10;
  localparam int unsigned EXT_W   = ACC_W + 1 - DELTA_W;
  localparam int unsigned MAG_W   = 7;
  localparam int unsigned MAG_MAX = 2**MAG_W - 1;
  localparam int unsigned SPD_POS = 10;
  localparam int unsigned SIG_POS = 15;
  localparam int unsigned Y_POS   = 16;
  localparam int unsigned X_POS   = 24;
  localparam int          SAT_LIM = 2**(ACC_W-1) - 1;
  localparam logic signed [ACC_W:0] SAT_P = (ACC_W+1)'(SAT_LIM);
  localparam logic signed [ACC_W:0] SAT_N = -SAT_P;

  typedef enum logic {IDLE, LATCH} state_t;

  state_t                   state, state_nxt;
  logic                     clk_q;
  logic                     clk_rise;
  logic                     strb_fall;
  logic                     load;
  logic                     shift;
  logic                     mouse_sel;
  logic [SR_W-1:0]          sr;
  logic [SR_W-1:0]          pad_word;
  logic [SR_W-1:0]          mouse_word;
  logic [SR_W-1:0]          load_word;
  logic [MAG_W-1:0]         mag_x, mag_y;
  logic signed [ACC_W-1:0]  acc_x, acc_y;
  logic [1:0]               speed;
  logic [1:0]               di_q;

  // Saturating add of a 9-bit signed delta into a 10-bit signed accumulator.
  function automatic logic signed [ACC_W-1:0] sat_add(
    input logic signed [ACC_W-1:0] a,
    input logic [DELTA_W-1:0]      d
  );
    logic signed [ACC_W:0] s;
    s = $signed({a[ACC_W-1], a}) + $signed({{EXT_W{d[DELTA_W-1]}}, d});
    if (s > SAT_P)      return ACC_W'(SAT_P);
    else if (s < SAT_N) return ACC_W'(SAT_N);
    else                return ACC_W'(s);
  endfunction

  function automatic logic [MAG_W-1:0] mag_of(input logic signed [ACC_W-1:0] a);
    logic [ACC_W-1:0] u;
    u = a[ACC_W-1] ? ACC_W'(-a) : ACC_W'(a);
    return (u > ACC_W'(MAG_MAX)) ? MAG_W'(MAG_MAX) : MAG_W'(u);
  endfunction

  assign clk_rise  = JOY_CLK & ~clk_q;
  assign mouse_sel = MOUSE_EN & MOUSE_MODE;
  assign JOY_DI    = di_q;

  // LATCH doubles as the previous-cycle strobe sample.
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      state <= IDLE;
      clk_q <= 1'b1;
    end else begin
      state <= state_nxt;
      clk_q <= JOY_CLK;
    end
  end

  always_comb begin
    state_nxt = state;
    strb_fall = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    case (state)
      IDLE: begin
        if (JOY_STRB) begin
          state_nxt = LATCH;
          load      = 1'b1;
        end else begin
          shift = clk_rise;
        end
      end
      LATCH: begin
        // A clock rise coinciding with the strobe fall must not skip bit 0.
        if (JOY_STRB) begin
          load = 1'b1;
        end else begin
          state_nxt = IDLE;
          strb_fall = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mag_x    = mag_of(acc_x);
  assign mag_y    = mag_of(acc_y);
  assign pad_word = {16'hFFFF, 4'b0000, BUTTONS};

  // Mouse report; magnitudes are sent MSB first.
  always_comb begin
    mouse_word              = '0;
    mouse_word[8]           = MOUSE_BTN[0];
    mouse_word[9]           = MOUSE_BTN[1];
    mouse_word[SPD_POS]     = speed[1];
    mouse_word[SPD_POS + 1] = speed[0];
    mouse_word[SIG_POS]     = 1'b1;
    mouse_word[Y_POS]       = acc_y[ACC_W-1];
    mouse_word[X_POS]       = acc_x[ACC_W-1];
    for (int i = 0; i < MAG_W; i++) begin
      mouse_word[Y_POS + 1 + i] = mag_y[MAG_W - 1 - i];
      mouse_word[X_POS + 1 + i] = mag_x[MAG_W - 1 - i];
    end
  end

  assign load_word = mouse_sel ? mouse_word : pad_word;

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      sr   <= '1;
      di_q <= 2'b10;
    end else begin
      if (load) begin
        sr <= load_word;
      end else if (shift) begin
        sr <= {1'b1, sr[SR_W-1:1]};
      end
      di_q <= {1'b1, ~sr[0]};
    end
  end

  if (MOUSE_EN) begin : g_mouse
    logic signed [ACC_W-1:0] base_x, base_y;

    assign base_x = strb_fall ? '0 : acc_x;
    assign base_y = strb_fall ? '0 : acc_y;

    always_ff @(posedge MCLK) begin
      if (RESET) begin
        acc_x <= '0;
        acc_y <= '0;
        speed <= 2'd0;
      end else begin
        acc_x <= MOUSE_STB ? sat_add(base_x, MOUSE_DX) : base_x;
        acc_y <= MOUSE_STB ? sat_add(base_y, MOUSE_DY) : base_y;
        if (clk_rise && JOY_STRB && MOUSE_MODE) begin
          speed <= (speed == 2'd2) ? 2'd0 : speed + 2'd1;
        end
      end
    end
  end else begin : g_no_mouse
    assign acc_x = '0;
    assign acc_y = '0;
    assign speed = 2'd0;
  end

endmodule

// File: tb/tb_snes_joy_responder.sv
// Self-checking bench for snes_joy_responder: directed scenarios plus randomized
// frames, compared against a report model built from the protocol rules.
module tb_snes_joy_responder;

  logic        MCLK = 1'b0;
  logic        RESET = 1'b1;
  logic        JOY_STRB = 1'b0;
  logic        JOY_CLK = 1'b1;
  logic [1:0]  JOY_DI;
  logic        MOUSE_MODE = 1'b0;
  logic [11:0] BUTTONS = '0;
  logic [8:0]  MOUSE_DX = '0;
  logic [8:0]  MOUSE_DY = '0;
  logic [1:0]  MOUSE_BTN = '0;
  logic        MOUSE_STB = 1'b0;

  int checks = 0;
  int errors = 0;
  int mx = 0, my = 0, spd = 0;

  always #5 MCLK = ~MCLK;

  snes_joy_responder #(.MOUSE_EN(1'b1)) dut (
    .MCLK(MCLK), .RESET(RESET), .JOY_STRB(JOY_STRB), .JOY_CLK(JOY_CLK),
    .JOY_DI(JOY_DI), .MOUSE_MODE(MOUSE_MODE), .BUTTONS(BUTTONS),
    .MOUSE_DX(MOUSE_DX), .MOUSE_DY(MOUSE_DY), .MOUSE_BTN(MOUSE_BTN),
    .MOUSE_STB(MOUSE_STB)
  );

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 511) return 511;
    if (v < -511) return -511;
    return v;
  endfunction

  function automatic int clamp_mag(input int v);
    int a;
    a = (v < 0) ? -v : v;
    return (a > 127) ? 127 : a;
  endfunction

  function automatic logic [31:0] pad_report(input logic [11:0] b);
    return {16'hFFFF, 4'h0, b};
  endfunction

  // Report bits in transmission order (index = bit number on the wire).
  function automatic logic [31:0] mouse_report(input int ax, input int ay, input int sp,
                                               input logic [1:0] btn);
    logic [31:0] w;
    int m;
    w     = '0;
    w[8]  = btn[0];
    w[9]  = btn[1];
    w[10] = 1'(sp / 2);
    w[11] = 1'(sp % 2);
    w[15] = 1'b1;
    w[16] = (ay < 0);
    m = clamp_mag(ay);
    for (int i = 0; i < 7; i++) w[17 + i] = 1'((m >> (6 - i)) & 1);
    w[24] = (ax < 0);
    m = clamp_mag(ax);
    for (int i = 0; i < 7; i++) w[25 + i] = 1'((m >> (6 - i)) & 1);
    return w;
  endfunction

  task automatic pulse();
    JOY_CLK = 1'b0;
    tick(); tick();
    JOY_CLK = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic stb(input int dx, input int dy);
    MOUSE_DX  = 9'(dx);
    MOUSE_DY  = 9'(dy);
    MOUSE_STB = 1'b1;
    tick();
    MOUSE_STB = 1'b0;
    mx = sat(mx + dx);
    my = sat(my + dy);
  endtask

  // Strobe with optional clock pulses during the high phase; returns the expected report.
  task automatic strobe_frame(input int pulses, output logic [31:0] rep);
    JOY_STRB = 1'b1;
    tick(); tick();
    for (int p = 0; p < pulses; p++) begin
      JOY_CLK = 1'b0;
      tick(); tick();
      JOY_CLK = 1'b1;
      tick(); tick();
      if (MOUSE_MODE) spd = (spd + 1) % 3;
    end
    rep = MOUSE_MODE ? mouse_report(mx, my, spd, MOUSE_BTN) : pad_report(BUTTONS);
    JOY_STRB = 1'b0;
    tick(); tick(); tick();
    mx = 0;
    my = 0;
  endtask

  task automatic read_range(input logic [31:0] rep, input int first, input int last,
                            input string tag);
    logic e;
    for (int k = first; k <= last; k++) begin
      if (k != 0) pulse();
      e = (k < 32) ? ~rep[k] : 1'b0;
      check($sformatf("%s bit%0d", tag, k), JOY_DI, {1'b1, e});
    end
  endtask

  initial begin
    logic [31:0] rep;
    logic        b;

    // Reset state
    tick(); tick();
    check("reset di", JOY_DI, 2'b10);
    RESET = 1'b0;
    pulse(); pulse();
    check("idle after reset", JOY_DI, 2'b10);

    // Pad latch/shift: R and B pressed, read past the end of the frame
    BUTTONS = 12'h801;
    strobe_frame(0, rep);
    read_range(rep, 0, 20, "pad801");

    // Live strobe: data follows ~B with two-cycle latency, pulses do not shift
    JOY_STRB = 1'b1;
    b = 1'b0;
    BUTTONS = 12'h000;
    tick(); tick(); tick();
    for (int i = 0; i < 4; i++) begin
      b = ~b;
      BUTTONS[0] = b;
      tick();
      check("live lag1", JOY_DI, {1'b1, b});
      tick();
      check("live lag2", JOY_DI, {1'b1, ~b});
      pulse();
      check("live pulse", JOY_DI, {1'b1, ~b});
    end
    BUTTONS = 12'($urandom);
    tick(); tick();
    rep = pad_report(BUTTONS);
    JOY_STRB = 1'b0;
    tick(); tick(); tick();
    read_range(rep, 0, 16, "live end");

    // Mouse live strobe shows logical 0 on bit 0
    MOUSE_MODE = 1'b1;
    JOY_STRB = 1'b1;
    tick(); tick();
    check("mouse live", JOY_DI, 2'b11);
    JOY_STRB = 1'b0;
    tick(); tick();
    mx = 0; my = 0;

    // Mouse report with clamped Y, then a zero-motion frame
    MOUSE_BTN = 2'b10;
    stb(5, 0); stb(0, -150); stb(0, -150);
    strobe_frame(0, rep);
    read_range(rep, 0, 33, "mouse1");
    strobe_frame(0, rep);
    read_range(rep, 0, 33, "mouse zero");

    // Saturation at +-511 changes the sign of the later result
    MOUSE_BTN = 2'b01;
    repeat (4) stb(255, -256);
    repeat (3) stb(-255, 255);
    strobe_frame(0, rep);
    read_range(rep, 0, 33, "sat");

    // Speed cycle 1,2,0
    for (int f = 0; f < 3; f++) begin
      strobe_frame(1, rep);
      read_range(rep, 0, 15, $sformatf("speed%0d", f));
    end

    // MOUSE_STB on the strobe-fall cycle
    MOUSE_BTN = 2'b00;
    JOY_STRB = 1'b1;
    tick(); tick();
    rep = mouse_report(mx, my, spd, MOUSE_BTN);
    JOY_STRB = 1'b0;
    MOUSE_DX = 9'd3; MOUSE_DY = 9'd0; MOUSE_STB = 1'b1;
    tick();
    MOUSE_STB = 1'b0;
    tick(); tick();
    mx = 3; my = 0;
    read_range(rep, 0, 33, "stbfall cur");
    strobe_frame(0, rep);
    read_range(rep, 0, 33, "stbfall next");

    // Clock rise on the strobe-fall cycle
    MOUSE_MODE = 1'b0;
    BUTTONS = 12'($urandom);
    JOY_STRB = 1'b1;
    tick();
    JOY_CLK = 1'b0;
    tick(); tick();
    rep = pad_report(BUTTONS);
    JOY_STRB = 1'b0;
    JOY_CLK = 1'b1;
    tick(); tick(); tick();
    mx = 0; my = 0;
    read_range(rep, 0, 17, "clkfall");

    // Mode change mid-frame does not alter the frame in flight
    BUTTONS = 12'h5A3;
    strobe_frame(0, rep);
    read_range(rep, 0, 3, "modechg");
    MOUSE_MODE = 1'b1;
    read_range(rep, 4, 17, "modechg");

    // Leave speed nonzero, then reset mid-frame
    strobe_frame(1, rep);
    read_range(rep, 0, 11, "prereset");
    MOUSE_MODE = 1'b0;
    BUTTONS = 12'h3C5;
    strobe_frame(0, rep);
    read_range(rep, 0, 5, "midreset");
    stb(40, -40);
    RESET = 1'b1;
    tick();
    check("mid reset di", JOY_DI, 2'b10);
    RESET = 1'b0;
    spd = 0; mx = 0; my = 0;
    pulse();
    check("post reset idle", JOY_DI, 2'b10);
    strobe_frame(0, rep);
    read_range(rep, 0, 16, "postreset pad");
    MOUSE_MODE = 1'b1;
    strobe_frame(0, rep);
    read_range(rep, 0, 33, "postreset mouse");

    // Randomized frames
    for (int f = 0; f < 8; f++) begin
      int n;
      MOUSE_MODE = 1'($urandom_range(0, 1));
      BUTTONS    = 12'($urandom);
      MOUSE_BTN  = 2'($urandom);
      n = $urandom_range(0, 4);
      for (int s = 0; s < n; s++)
        stb(int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256);
      strobe_frame(int'($urandom_range(0, 2)), rep);
      read_range(rep, 0, MOUSE_MODE ? 33 : 17, $sformatf("rand%0d", f));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
